// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch port, data port and shared-memory port bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [AW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [AW-1:0] d_wdata;
  logic [AW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic [AW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall_f;
  logic          stall_m;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and data requests onto one single-port memory,
// data first with a bounded number of consecutive data grants while a fetch waits.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [AW-1:0] mem_wdata_q;
  logic [AW-1:0] if_rdata_q;
  logic [AW-1:0] d_rdata_q;
  logic          if_ready_q;
  logic          d_ready_q;
  logic          grant_d;
  logic          grant_i;

  // Data wins ties until the pending fetch has been passed over STARVE_LIMIT times.
  always_comb begin
    grant_d = bus.d_req && !(bus.if_req && (starve_cnt == LIMIT));
    grant_i = bus.if_req && !grant_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            if (!bus.if_req)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CW'(1);
          end else if (grant_i) begin
            state       <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            starve_cnt  <= '0;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack) begin
            if_rdata_q <= bus.mem_rdata;
            if_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state      <= DONE;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            if (!mem_we_q)
              d_rdata_q <= bus.mem_rdata;
            d_ready_q <= 1'b1;
            mem_req_q <= 1'b0;
            state     <= DONE;
          end
        end
        default: begin
          if_ready_q <= 1'b0;
          d_ready_q  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.stall_f   = bus.if_req & ~if_ready_q;
  assign bus.stall_m   = bus.d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector and corner-sequence bench for mem_arbiter.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_arbiter_if #(.AW(32)) bus ();

  mem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] mrdata;
    logic        drop;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_mem_we"},    {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
    chk({tag, "_d_rdata"},   bus.d_rdata, 32'd0);
    chk({tag, "_if_ready"},  {31'd0, bus.if_ready}, 32'd0);
    chk({tag, "_d_ready"},   {31'd0, bus.d_ready}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    reset = 1'b0;

    //            is_d we  addr          wdata  dly mrdata        drop exp_if        exp_d
    vecs[0] = '{1'b0, 1'b0, 32'h0,        32'h0, 2, 32'hE04F000F, 1'b0, 32'hE04F000F, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h64,       32'h0, 1, 32'h12345678, 1'b0, 32'hE04F000F, 32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 32'h64,       32'h7, 3, 32'hDEADBEEF, 1'b0, 32'hE04F000F, 32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 32'h4,        32'h0, 4, 32'hE3A01005, 1'b1, 32'hE3A01005, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, 1, 32'hFFFFFFFF, 1'b1, 32'hE3A01005, 32'hFFFFFFFF};

    tick();
    tick();
    chk_all_zero("reset");
    chk("reset_stall_f", {31'd0, bus.stall_f}, 32'd0);
    reset = 1'b1;
    tick();

    // Stray ack while idle must not touch anything.
    bus.mem_rdata = 32'h55AA55AA;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    tick();
    chk_all_zero("idle_ack");

    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_d) begin
        bus.d_req   = 1'b1;
        bus.d_we    = vecs[v].we;
        bus.d_addr  = vecs[v].addr;
        bus.d_wdata = vecs[v].wdata;
      end else begin
        bus.if_req  = 1'b1;
        bus.if_addr = vecs[v].addr;
      end
      tick();
      chk($sformatf("v%0d_mem_req", v), {31'd0, bus.mem_req}, 32'd1);
      chk($sformatf("v%0d_mem_addr", v), bus.mem_addr, vecs[v].addr);
      chk($sformatf("v%0d_mem_we", v), {31'd0, bus.mem_we}, {31'd0, vecs[v].we});
      if (vecs[v].we)
        chk($sformatf("v%0d_mem_wdata", v), bus.mem_wdata, vecs[v].wdata);
      if (vecs[v].drop) begin
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
      for (int c = 0; c < vecs[v].delay; c++) begin
        bus.d_addr  = ~vecs[v].addr;
        bus.if_addr = ~vecs[v].addr;
        bus.d_wdata = 32'h00000BAD;
        bus.d_we    = ~vecs[v].we;
        tick();
        chk($sformatf("v%0d_hold_req", v), {31'd0, bus.mem_req}, 32'd1);
        chk($sformatf("v%0d_hold_addr", v), bus.mem_addr, vecs[v].addr);
        chk($sformatf("v%0d_hold_we", v), {31'd0, bus.mem_we}, {31'd0, vecs[v].we});
        if (vecs[v].we)
          chk($sformatf("v%0d_hold_wdata", v), bus.mem_wdata, vecs[v].wdata);
        if (!vecs[v].drop)
          chk($sformatf("v%0d_stall", v),
              {31'd0, vecs[v].is_d ? bus.stall_m : bus.stall_f}, 32'd1);
      end
      bus.mem_rdata = vecs[v].mrdata;
      bus.mem_ack   = 1'b1;
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      chk($sformatf("v%0d_if_ready", v), {31'd0, bus.if_ready}, {31'd0, ~vecs[v].is_d});
      chk($sformatf("v%0d_d_ready", v), {31'd0, bus.d_ready}, {31'd0, vecs[v].is_d});
      chk($sformatf("v%0d_req_drop", v), {31'd0, bus.mem_req}, 32'd0);
      chk($sformatf("v%0d_if_rdata", v), bus.if_rdata, vecs[v].exp_if);
      chk($sformatf("v%0d_d_rdata", v), bus.d_rdata, vecs[v].exp_d);
      chk($sformatf("v%0d_stall_done", v), {31'd0, bus.stall_f | bus.stall_m}, 32'd0);
      idle_inputs();
      tick();
      chk($sformatf("v%0d_ready_once", v), {31'd0, bus.if_ready | bus.d_ready}, 32'd0);
      chk($sformatf("v%0d_if_rdata_hold", v), bus.if_rdata, vecs[v].exp_if);
      chk($sformatf("v%0d_d_rdata_hold", v), bus.d_rdata, vecs[v].exp_d);
    end

    // Simultaneous requests: data first, fetch stalled until its own turn.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h8;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h64;
    tick();
    chk("sim_first_addr", bus.mem_addr, 32'h64);
    chk("sim_stall_f", {31'd0, bus.stall_f}, 32'd1);
    chk("sim_stall_m", {31'd0, bus.stall_m}, 32'd1);
    tick();
    bus.mem_rdata = 32'h00000042;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("sim_d_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("sim_d_rdata", bus.d_rdata, 32'h00000042);
    chk("sim_stall_f_done", {31'd0, bus.stall_f}, 32'd1);
    bus.d_req = 1'b0;
    tick();
    chk("sim_stall_f_idle", {31'd0, bus.stall_f}, 32'd1);
    tick();
    chk("sim_second_req", {31'd0, bus.mem_req}, 32'd1);
    chk("sim_second_addr", bus.mem_addr, 32'h8);
    tick();
    bus.mem_rdata = 32'hE1A00000;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("sim_if_ready", {31'd0, bus.if_ready}, 32'd1);
    chk("sim_if_rdata", bus.if_rdata, 32'hE1A00000);
    chk("sim_stall_f_clear", {31'd0, bus.stall_f}, 32'd0);
    idle_inputs();
    tick();

    // Starvation: both held high, fetch must win every fifth grant.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h200;
    for (int g = 0; g < 10; g++) begin
      for (int n = 0; n < 4; n++) begin
        tick();
        if (bus.mem_req) break;
      end
      chk($sformatf("starve_grant%0d", g), bus.mem_addr,
          (g == 4 || g == 9) ? 32'h100 : 32'h200);
      tick();
      bus.mem_rdata = g;
      bus.mem_ack   = 1'b1;
      tick();
      bus.mem_ack   = 1'b0;
    end
    idle_inputs();
    tick();
    tick();

    // Reset in the middle of a load, then a stray ack.
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h64;
    tick();
    chk("rst_busy_req", {31'd0, bus.mem_req}, 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("rst_async");
    bus.d_req = 1'b0;
    tick();
    reset = 1'b1;
    bus.mem_rdata = 32'h00000077;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk_all_zero("rst_stray");
    tick();
    chk("rst_no_pulse", {31'd0, bus.d_ready}, 32'd0);

    // First grant lands on the first rising edge after reset releases.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h30;
    tick();
    chk("post_rst_grant", {31'd0, bus.mem_req}, 32'd1);
    chk("post_rst_addr", bus.mem_addr, 32'h30);
    tick();
    bus.mem_rdata = 32'hCAFE0001;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("post_rst_ready", {31'd0, bus.d_ready}, 32'd1);
    chk("post_rst_rdata", bus.d_rdata, 32'hCAFE0001);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum number of consecutive data grants while a fetch is pending.
REQ-002 Parameter AW, default 32: address and data width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low; reset=0 forces the reset state immediately, regardless of clk.
REQ-005 if_req  in  1  instruction-fetch request; held high by the requester until if_ready.
REQ-006 if_addr  in  AW  fetch address (PCF).
REQ-007 if_rdata  out  AW  fetched instruction; valid when if_ready=1.
REQ-008 if_ready  out  1  one-cycle completion pulse for a fetch.
REQ-009 d_req  in  1  data request; held high by the requester until d_ready.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  AW  data address (ALUOutM).
REQ-012 d_wdata  in  AW  store data (WriteDataM).
REQ-013 d_rdata  out  AW  load data; valid when d_ready=1.
REQ-014 d_ready  out  1  one-cycle completion pulse for a data access.
REQ-015 mem_req  out  1  request to the shared single-port memory.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  AW  memory address.
REQ-018 mem_wdata  out  AW  memory write data.
REQ-019 mem_rdata  in  AW  memory read data; valid when mem_ack=1.
REQ-020 mem_ack  in  1  memory completion, one cycle, arriving one or more cycles after mem_req rises.
REQ-021 stall_f  out  1  fetch stall, combinational: if_req & ~if_ready.
REQ-022 stall_m  out  1  memory-stage stall, combinational: d_req & ~d_ready.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, BUSY_I, BUSY_D, DONE.
REQ-024 IDLE with neither request: remain in IDLE.
REQ-025 IDLE with one request: grant that request.
REQ-026 IDLE with both requests: grant data, unless starve_cnt==STARVE_LIMIT, in which case grant fetch.
REQ-027 On a grant, the winning port's address, we and wdata SHALL be latched, mem_req SHALL be registered high, and the FSM SHALL go to BUSY_I or BUSY_D. A fetch always has mem_we=0.
REQ-028 mem_req, mem_we, mem_addr and mem_wdata SHALL be driven from the latched values and held stable until mem_ack; changes on the port inputs during BUSY SHALL be ignored.
REQ-029 BUSY_x with mem_ack=1: capture mem_rdata into the granted port's rdata register (loads and fetches only), drop mem_req, go to DONE.
REQ-030 BUSY_x with mem_ack=0: remain in BUSY_x.
REQ-031 DONE: assert if_ready or d_ready (the granted port only) for exactly one cycle, then go to IDLE.
REQ-032 Latency: grant decided in IDLE at cycle 0, mem_req high at cycle 1; mem_ack at cycle k gives ready at cycle k+1; requests are re-sampled in IDLE at cycle k+2.
REQ-033 A store SHALL leave d_rdata unchanged.
REQ-034 Each rdata register SHALL hold its value until the next completion on that port.
REQ-035 starve_cnt (width clog2(STARVE_LIMIT+1)): increment on a data grant while if_req=1, saturating at STARVE_LIMIT.
REQ-036 starve_cnt SHALL clear on a fetch grant, and on a data grant while if_req=0.
REQ-037 mem_ack in IDLE or DONE SHALL be ignored: no state change and no rdata update.
REQ-038 A requester dropping its req during BUSY SHALL NOT abort the transaction; the ready pulse is still issued.

Reset
REQ-039 reset=0 SHALL asynchronously force: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_ready=0, d_ready=0, starve_cnt=0.
REQ-040 A transaction in flight at reset SHALL be abandoned, and a later stray mem_ack SHALL be ignored per REQ-037.
REQ-041 The first grant after reset deasserts SHALL occur on the first rising edge with reset=1.

Verification
REQ-042 Fetch only: if_addr=0x0, memory acks 2 cycles after mem_req, mem_rdata=0xE04F000F -> if_ready pulses once with if_rdata=0xE04F000F; mem_we=0 throughout.
REQ-043 Simultaneous requests: if_req=1 and d_req=1 (load, d_addr=0x64) -> data is granted first and stall_f=1 until fetch completes; fetch is granted next.
REQ-044 Starvation: if_req held high and d_req re-asserted every IDLE, STARVE_LIMIT=4 -> four data grants, then one fetch grant, then starve_cnt=0.
REQ-045 Store: d_we=1, d_addr=0x64, d_wdata=7 -> mem_we=1, mem_addr=0x64, mem_wdata=7 held until ack; d_ready pulses; d_rdata unchanged.
REQ-046 Reset mid-BUSY_D, followed by a stray mem_ack -> state=IDLE, all outputs 0, no ready pulse.
REQ-047 Input change during BUSY: d_addr changed while in BUSY_D -> mem_addr keeps the latched value.
